// File: rtl/dram_rd_ctrl_pkg.sv
// Shared definitions for the cache-side DRAM read blocks: the read FSM
// state encoding and the default burst/timeout sizing.
package dram_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  localparam int         DEFAULT_BLOCK_SIZE     = 16;
  localparam logic [7:0] DEFAULT_TIMEOUT_CYCLES = 8'd255;

endpackage

// File: rtl/dram_rd_ctrl.sv
// DRAM burst read controller: turns a held cache read request into
// BLOCK_SIZE single-word memory reads at ascending addresses and returns
// each word with a one-cycle dram_val pulse.
// Optional feature: define DRAM_RD_TIMEOUT_EN to build a per-word wait
// counter that substitutes a zero word and raises the sticky rd_err flag
// when memory fails to ack within TIMEOUT_CYCLES cycles.
module dram_rd_ctrl
  import dram_rd_ctrl_pkg::*;
#(
  parameter int         BLOCK_SIZE     = DEFAULT_BLOCK_SIZE,
  parameter logic [7:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        dram_rd_req,
  input  logic [31:0] dram_rd_addr,
  output logic [31:0] dram_rd_data,
  output logic        dram_val,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rd_busy,
  output logic        rd_err
);

  localparam int                BEAT_W    = $clog2(BLOCK_SIZE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

  rd_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic [31:0]       base_q;
  logic              abort_q;      // requester dropped req during this access
  logic              timeout_hit;  // current READ cycle is treated as an ack
  logic              word_done;    // access completes at the coming edge
  logic              deliver;      // completed word goes back to the cache
  logic [31:0]       word_data;

  assign word_done = (state_q == READ) && (mem_ack || timeout_hit);
  assign deliver   = word_done && dram_rd_req && !abort_q;
  assign word_data = mem_ack ? mem_rdata : 32'h0000_0000;

`ifdef DRAM_RD_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       rd_err_q;

  // The cycle in which the wait counter shows TIMEOUT_CYCLES-1 is the
  // TIMEOUT_CYCLES-th cycle spent waiting, so that cycle closes the access.
  assign timeout_hit = (state_q == READ) && !mem_ack &&
                       (wait_cnt_q == TIMEOUT_CYCLES - 8'd1);

  // Per-word wait counter (zero outside READ) and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
      rd_err_q   <= 1'b0;
    end else begin
      if (state_q == READ) wait_cnt_q <= wait_cnt_q + 8'd1;
      else                 wait_cnt_q <= 8'd0;
      if (timeout_hit)     rd_err_q   <= 1'b1;
    end
  end

  assign rd_err = rd_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rd_err      = 1'b0;
`endif

  // State register, burst base/beat tracking and registered return data.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      base_q       <= 32'h0000_0000;
      abort_q      <= 1'b0;
      dram_rd_data <= 32'h0000_0000;
      dram_val     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dram_val <= deliver;
      abort_q  <= (state_d == READ) && (abort_q || !dram_rd_req);
      if (state_q == IDLE && dram_rd_req) begin
        base_q <= dram_rd_addr;
        beat_q <= '0;
      end
      if (word_done) beat_q       <= beat_q + BEAT_W'(1);
      if (deliver)   dram_rd_data <= word_data;
    end
  end

  // Next-state logic and memory-side outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    mem_addr  = 32'h0000_0000;
    rd_busy   = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (dram_rd_req) state_d = READ;
      end
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + 32'(beat_q);
        if (word_done) begin
          if (!dram_rd_req || abort_q) state_d = IDLE;
          else if (beat_q == LAST_BEAT) state_d = DONE;
          else                          state_d = GAP;
        end
      end
      GAP: begin
        state_d = dram_rd_req ? READ : IDLE;
      end
      DONE: begin
        if (!dram_rd_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dram_rd_ctrl.sv
// Self-checking bench for dram_rd_ctrl: a behavioural memory answers reads
// with an address-derived word after a configurable wait; returned words,
// ack addresses and pulse spacing are compared to the burst rules.
module tb_dram_rd_ctrl;

  logic        clock = 1'b0;
  logic        rst;
  logic        dram_rd_req;
  logic [31:0] dram_rd_addr;
  logic [31:0] dram_rd_data;
  logic        dram_val;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rd_busy;
  logic        rd_err;

  int vectors     = 0;
  int miscompares = 0;

  int          cyc      = 0;
  int          wait_cfg = 0;
  bit          mem_mute = 1'b0;
  int          wait_ctr = 0;
  int          stab_err = 0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] seed;

  logic [31:0] val_data_q[$];
  int          val_cyc_q[$];
  logic [31:0] ack_addr_q[$];

  always #5 clock = ~clock;

  dram_rd_ctrl dut (
    .clock        (clock),
    .rst          (rst),
    .dram_rd_req  (dram_rd_req),
    .dram_rd_addr (dram_rd_addr),
    .dram_rd_data (dram_rd_data),
    .dram_val     (dram_val),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .rd_busy      (rd_busy),
    .rd_err       (rd_err)
  );

  // Contents of the behavioural memory at a word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, log returned words, then
  // drive the memory response seen at the next rising edge.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (dram_val === 1'b1) begin
      val_data_q.push_back(dram_rd_data);
      val_cyc_q.push_back(cyc);
    end
    if (mem_rd_en === 1'b1) begin
      if (wait_ctr > 0 && mem_addr !== prev_addr) stab_err++;
      prev_addr = mem_addr;
      if (!mem_mute && wait_ctr == wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        ack_addr_q.push_back(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      wait_ctr++;
    end else begin
      wait_ctr  = 0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic clear_logs();
    val_data_q.delete();
    val_cyc_q.delete();
    ack_addr_q.delete();
    stab_err = 0;
  endtask

  // Full burst from base with wait_c memory wait cycles per word.
  task automatic run_burst(input logic [31:0] base, input int wait_c);
    int start;
    int n;
    clear_logs();
    wait_cfg     = wait_c;
    dram_rd_req  = 1'b1;
    dram_rd_addr = base;
    start        = cyc;
    tick();
    dram_rd_addr = $urandom;
    n = 0;
    while (val_data_q.size() < 16 && n < 400) begin
      tick();
      n++;
    end
    check("burst_word_count", 32'(val_data_q.size()), 32'd16);
    if (val_cyc_q.size() > 0)
      check("first_latency", 32'(val_cyc_q[0] - start), 32'(wait_c + 2));
    for (int i = 0; i < val_data_q.size(); i++)
      check("burst_data", val_data_q[i], mem_word(base + 32'(i)));
    for (int i = 1; i < val_cyc_q.size(); i++)
      check("pulse_spacing", 32'(val_cyc_q[i] - val_cyc_q[i-1]), 32'(wait_c + 2));
    for (int i = 0; i < ack_addr_q.size(); i++)
      check("mem_addr_seq", ack_addr_q[i], base + 32'(i));
    repeat (4) tick();
    check("done_no_extra", 32'(val_data_q.size()), 32'd16);
    check("done_busy", 32'(rd_busy), 32'd1);
    check("done_no_read", 32'(mem_rd_en), 32'd0);
    check("addr_stable", 32'(stab_err), 32'd0);
    dram_rd_req = 1'b0;
    tick();
    check("idle_after_drop", 32'(rd_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] base;
    int n;
    int a_cyc;
    seed         = $urandom;
    rst          = 1'b1;
    dram_rd_req  = 1'b0;
    dram_rd_addr = 32'h0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'h0;
    tick();
    tick();
    check("rst_data", dram_rd_data, 32'h0);
    check("rst_val", 32'(dram_val), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_busy", 32'(rd_busy), 32'd0);
    check("rst_err", 32'(rd_err), 32'd0);
    rst = 1'b0;
    tick();

    // Zero-wait memory from 0x40, then 3 wait cycles from a random base.
    run_burst(32'h0000_0040, 0);
    run_burst($urandom, 3);

    // Abort during the access for word 6.
    clear_logs();
    base         = $urandom;
    wait_cfg     = 2;
    dram_rd_req  = 1'b1;
    dram_rd_addr = base;
    tick();
    n = 0;
    while (val_data_q.size() < 5 && n < 100) begin tick(); n++; end
    n = 0;
    while (mem_rd_en !== 1'b1 && n < 20) begin tick(); n++; end
    dram_rd_req = 1'b0;
    n = 0;
    while (ack_addr_q.size() < 6 && n < 20) begin tick(); n++; end
    check("abort_outstanding_done", 32'(ack_addr_q.size()), 32'd6);
    a_cyc = cyc;
    tick();
    check("abort_idle_gap", 32'(cyc - a_cyc), 32'd1);
    check("abort_idle", 32'(rd_busy), 32'd0);
    repeat (3) tick();
    check("abort_no_val", 32'(val_data_q.size()), 32'd5);
    if (ack_addr_q.size() == 6) check("abort_addr", ack_addr_q[5], base + 32'd5);
    run_burst($urandom, 0);

    // Reset at beat 7 followed by a stray ack.
    clear_logs();
    wait_cfg     = 1;
    dram_rd_req  = 1'b1;
    dram_rd_addr = $urandom;
    tick();
    n = 0;
    while (ack_addr_q.size() < 7 && n < 100) begin tick(); n++; end
    n = 0;
    while (mem_rd_en !== 1'b1 && n < 20) begin tick(); n++; end
    rst         = 1'b1;
    dram_rd_req = 1'b0;
    tick();
    check("midrst_data", dram_rd_data, 32'h0);
    check("midrst_val", 32'(dram_val), 32'd0);
    check("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    check("midrst_addr", mem_addr, 32'h0);
    check("midrst_busy", 32'(rd_busy), 32'd0);
    check("midrst_err", 32'(rd_err), 32'd0);
    rst       = 1'b0;
    n         = val_data_q.size();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("late_ack_no_val", 32'(val_data_q.size() - n), 32'd0);
    check("late_ack_data", dram_rd_data, 32'h0);
    check("late_ack_idle", 32'(rd_busy), 32'd0);

    // Address wrap past 0xFFFF_FFFF.
    run_burst(32'hFFFF_FFF8, 0);
    if (ack_addr_q.size() == 16) begin
      check("wrap_top", ack_addr_q[7], 32'hFFFF_FFFF);
      check("wrap_zero", ack_addr_q[8], 32'h0000_0000);
      check("wrap_end", ack_addr_q[15], 32'h0000_0007);
    end else begin
      check("wrap_ack_count", 32'(ack_addr_q.size()), 32'd16);
    end

`ifdef DRAM_RD_TIMEOUT_EN
    // Memory never acks: the 255th waiting cycle closes the access.
    clear_logs();
    mem_mute     = 1'b1;
    dram_rd_req  = 1'b1;
    dram_rd_addr = $urandom;
    tick();
    n = 0;
    while (mem_rd_en !== 1'b1 && n < 5) begin tick(); n++; end
    a_cyc = cyc;
    n = 0;
    while (val_data_q.size() < 1 && n < 400) begin tick(); n++; end
    check("tmo_pulse", 32'(val_data_q.size()), 32'd1);
    if (val_cyc_q.size() > 0) begin
      check("tmo_delay", 32'(val_cyc_q[0] - a_cyc), 32'd255);
      check("tmo_data", val_data_q[0], 32'h0);
    end
    check("tmo_err_set", 32'(rd_err), 32'd1);
    dram_rd_req = 1'b0;
    mem_mute    = 1'b0;
    repeat (4) tick();
    check("tmo_err_sticky", 32'(rd_err), 32'd1);
    run_burst($urandom, 0);
    check("tmo_err_after_burst", 32'(rd_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tmo_err_cleared", 32'(rd_err), 32'd0);
`else
    check("no_timeout_err", 32'(rd_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
